dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port data memory (12-bit address, 12-bit data) between NUM_CORES processor cores.
- Each core presents the same access as its processor `dm_en`/`ar_out` path. The arbiter picks one requester per cycle with round-robin priority.
- It drives the memory port registered. It returns read data with a per-core valid pulse.
- Sits between the core array and the data-memory instance at top level.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 12, data-memory address width
- DATA_W, 12, data-memory word width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CORES  per-core access request; held until the matching gnt
- we  in  NUM_CORES  per-core write flag (1 = write, 0 = read), valid with req
- addr  in  NUM_CORES*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_CORES*DATA_W  per-core write data, same packing
- gnt  out  NUM_CORES  one-hot grant pulse; core i's access is accepted this cycle
- rvalid  out  NUM_CORES  one-hot read-data-valid pulse
- rdata  out  DATA_W  read data, shared, qualified by rvalid
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_we  out  1  memory write enable (registered)
- mem_rd  out  1  memory read strobe (registered)
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid 1 cycle after mem_rd
- conflict_cnt  out  16  present only with DM_ARB_STATS_EN

Behaviour:
- Reset (rst=1 at an edge):
  - gnt, rvalid, mem_we, mem_rd = 0.
  - rdata, mem_addr, mem_wdata = 0.
  - Round-robin pointer ptr = 0 (core 0 highest priority).
  - The read pipeline is flushed.
- Arbitration, cycle t (combinational on registered state):
  - Winner w = first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping mod NUM_CORES.
  - No req set: no winner; memory strobes are 0 at t+1.
- Issue (edge ending cycle t, registered outputs valid in cycle t+1):
  - gnt[w]=1 for exactly one cycle.
  - mem_addr/mem_wdata = addr/wdata of core w.
  - mem_we = we[w]; mem_rd = ~we[w].
  - ptr <= (w+1) mod NUM_CORES.
  - ptr is unchanged when there is no winner.
- Requester rule: a core may drop req or change addr/we/wdata only in the cycle after it sees gnt. Holding req after gnt is a new back-to-back request.
- Read return:
  - mem_rdata is valid in cycle t+2.
  - It is registered into rdata, with rvalid[w]=1, in cycle t+3.
  - Read latency from first req sampled to rvalid is 3 cycles.
  - A 2-deep tag shift (core index + valid) carries w alongside the read.
- Writes produce no rvalid. Write completes at the memory in cycle t+1.
- Throughput: one access per cycle; reads and writes may interleave every cycle with no bubble.
- Fairness: with all NUM_CORES requesting continuously, each core is granted exactly once every NUM_CORES cycles.
- Boundaries:
  - addr = 0xFFF passed unchanged; no address checking.
  - A core granted last cycle and still requesting loses to any other requester (pointer has moved past it).
  - Single requester is granted every cycle.
  - rst mid-read: tag pipeline cleared, so no rvalid is issued for in-flight reads. The memory may still return data, which is ignored.
- No combinational path from req/addr to any output.

Optional Feature:
- Macro: DM_ARB_STATS_EN
- Defined:
  - conflict_cnt port exists.
  - Increments by 1 in each cycle where popcount(req) >= 2.
  - Saturates at 0xFFFF; cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package `dm_arb_pkg`:
  - default ADDR_W/DATA_W constants;
  - tag type {valid, core index [$clog2(NUM_CORES)-1:0]};
  - function rr_pick(req, ptr) returning the winner index and a found flag.
- One natural sub-module `rr_picker`: pure combinational rotate-priority encoder (req, ptr -> idx, found). The top holds the registers, tag pipe and optional counter.

Test Plan:
- Reset then single read:
  - core 2 req=1, we=0, addr=0x00A, memory preloaded 0x00A=0x5A5;
  - expect gnt=0100 one cycle later, mem_rd=1 with mem_addr=0x00A, then rvalid=0100 with rdata=0x5A5 three cycles after req.
- All 4 cores hold req continuously for 8 cycles after reset:
  - expect gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Core 0 write, core 1 read of the same address:
  - core 0 writes 0x123 to 0x040 while core 1 reads 0x040, both asserted in the same cycle;
  - expect core 0 granted first, core 1 next cycle, core 1 rvalid with rdata=0x123.
- Back-to-back reads from core 3 only (addr 0x001, 0x002, 0x003 on consecutive grants):
  - expect 3 consecutive rvalid=1000 pulses carrying the three data words in order, no bubbles.
- rst asserted one cycle after a read grant:
  - expect no rvalid afterwards, all outputs 0, next grant priority restarts at core 0.
- With DM_ARB_STATS_EN: cores 0 and 1 both request for 5 cycles, then only core 0 for 3 cycles;
  - expect conflict_cnt=5; without the macro, the bench compiles without the port.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// The tag index is sized for the largest supported core count (8).
package dm_arb_pkg;

    localparam int unsigned DefNumCores = 4;
    localparam int unsigned DefAddrW    = 12;
    localparam int unsigned DefDataW    = 12;
    localparam int unsigned MaxCores    = 8;
    localparam int unsigned IdxW        = $clog2(MaxCores);

    typedef logic [IdxW-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } tag_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    // Rotate-priority search: first set bit at ptr, ptr+1, ... wrapping mod n.
    function automatic pick_t rr_pick(input logic [MaxCores-1:0] req, input idx_t ptr,
                                      input int unsigned n);
        pick_t       res;
        int unsigned cand;
        res = '{found: 1'b0, idx: '0};
        for (int unsigned k = 0; k < MaxCores; k++) begin
            cand = (32'(ptr) + k) % n;
            if (!res.found && (k < n) && req[cand[IdxW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx_t'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Core-side request/response bus plus data-memory port of the arbiter.
// slave is the arbiter view; master is the core array / memory view.
interface dm_arbiter_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 12
);
    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        we;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata;
    logic [NUM_CORES-1:0]        gnt;
    logic [NUM_CORES-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_we;
    logic                        mem_rd;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, mem_rd
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, mem_rd
    );

endinterface

// File: rtl/rr_picker.sv
// Purely combinational rotate-priority encoder: picks the first requester at or after ptr.
module rr_picker
    import dm_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = DefNumCores
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  idx_t                 ptr_i,
    output idx_t                 idx_o,
    output logic                 found_o
);

    pick_t pick;

    always_comb begin
        pick    = rr_pick(MaxCores'(req_i), ptr_i, NUM_CORES);
        idx_o   = pick.idx;
        found_o = pick.found;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between NUM_CORES cores.
// Optional DM_ARB_STATS_EN adds a saturating conflict_cnt output.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = DefNumCores,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DM_ARB_STATS_EN
    output logic [15:0] conflict_cnt,
`endif
    dm_arbiter_if.slave bus
);

    idx_t pick_idx;
    logic pick_found;

    logic [NUM_CORES-1:0] gnt_q, gnt_d;
    logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 mem_we_q, mem_we_d;
    logic                 mem_rd_q, mem_rd_d;
    idx_t                 ptr_q, ptr_d;
    tag_t                 tag0_q, tag0_d;
    tag_t                 tag1_q, tag1_d;

    rr_picker #(
        .NUM_CORES(NUM_CORES)
    ) u_picker (
        .req_i  (bus.req),
        .ptr_i  (ptr_q),
        .idx_o  (pick_idx),
        .found_o(pick_found)
    );

    always_comb begin
        gnt_d       = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_rd_d    = 1'b0;
        ptr_d       = ptr_q;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (pick_found && (pick_idx == idx_t'(i))) begin
                gnt_d[i]    = 1'b1;
                mem_addr_d  = bus.addr[i*ADDR_W +: ADDR_W];
                mem_wdata_d = bus.wdata[i*DATA_W +: DATA_W];
                mem_we_d    = bus.we[i];
                mem_rd_d    = ~bus.we[i];
            end
        end
        if (pick_found) begin
            ptr_d = (pick_idx == idx_t'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
        end
        // Tag rides two stages alongside the read so rvalid lands as rdata is captured.
        tag0_d = '{valid: mem_rd_d, idx: pick_idx};
        tag1_d = tag0_q;
    end

    always_comb begin
        rvalid_d = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            rvalid_d[i] = tag1_q.valid && (tag1_q.idx == idx_t'(i));
        end
        rdata_d = tag1_q.valid ? bus.mem_rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            ptr_q       <= '0;
            tag0_q      <= '0;
            tag1_q      <= '0;
        end else begin
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_rd_q    <= mem_rd_d;
            ptr_q       <= ptr_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_rd    = mem_rd_q;

`ifdef DM_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (($countones(bus.req) >= 2) && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed stimulus pushes expected grants/reads,
// a negedge monitor pops and compares. Build with DM_ARB_STATS_EN to cover conflict_cnt.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 12;

    typedef struct {
        int            cyc;
        logic [NC-1:0] gnt;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct {
        int            cyc;
        logic [NC-1:0] rv;
        logic [DW-1:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t mon_g;
    rexp_t mon_r;

    logic [DW-1:0] mem [0:4095];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    dm_arbiter #(
        .NUM_CORES(NC),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef DM_ARB_STATS_EN
        .conflict_cnt(conflict_cnt),
`endif
        .bus         (bus)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        case (a)
            12'h00A: return 12'h5A5;
            12'h001: return 12'h111;
            12'h002: return 12'h222;
            12'h003: return 12'h333;
            default: return 12'h000;
        endcase
    endfunction

    // Synchronous-read memory model
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(AW'(i));
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int c, input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        bus.req[c]              = r;
        bus.we[c]               = w;
        bus.addr[c*AW +: AW]    = a;
        bus.wdata[c*DW +: DW]   = d;
    endtask

    // d is the write data for writes, or the expected read data for reads
    task automatic expect_gnt(input int c, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int at, input logic ret);
        gexp_t g;
        rexp_t r;
        g.cyc = at;
        g.gnt = '0;
        g.gnt[c] = 1'b1;
        g.addr = a;
        g.we = w;
        g.wdata = d;
        gq.push_back(g);
        if (!w && ret) begin
            r.cyc = at + 2;
            r.rv = g.gnt;
            r.data = d;
            rq.push_back(r);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 0);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 0);
    endtask

    always @(negedge clk) begin
        if (bus.gnt != '0) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", 32'(bus.gnt), 0);
            end else begin
                mon_g = gq.pop_front();
                chk("gnt_cycle", cyc, mon_g.cyc);
                chk("gnt_vec", 32'(bus.gnt), 32'(mon_g.gnt));
                chk("mem_addr", 32'(bus.mem_addr), 32'(mon_g.addr));
                chk("mem_we", 32'(bus.mem_we), 32'(mon_g.we));
                chk("mem_rd", 32'(bus.mem_rd), 32'(!mon_g.we));
                if (mon_g.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(mon_g.wdata));
            end
        end else begin
            chk("idle_strobes", 32'({bus.mem_we, bus.mem_rd}), 0);
        end
        if (bus.rvalid != '0) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 32'(bus.rvalid), 0);
            end else begin
                mon_r = rq.pop_front();
                chk("rvalid_cycle", cyc, mon_r.cyc);
                chk("rvalid_vec", 32'(bus.rvalid), 32'(mon_r.rv));
                chk("rdata", 32'(bus.rdata), 32'(mon_r.data));
            end
        end
    end

    initial begin
        int c;
        int d;
        int seq [8];
        rst = 1'b1;
        mem_init = 1'b1;
        bus.req = '0;
        bus.we = '0;
        bus.addr = '0;
        bus.wdata = '0;
        tick();
        tick();
        mem_init = 1'b0;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single read from core 2
        c = cyc;
        set_core(2, 1'b1, 1'b0, 12'h00A, 12'h000);
        expect_gnt(2, 1'b0, 12'h00A, 12'h5A5, c + 1, 1'b1);
        tick();
        set_core(2, 1'b0, 1'b0, 12'h000, 12'h000);
        repeat (5) tick();

        // Fairness: all cores requesting after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c = cyc;
        for (int i = 0; i < NC; i++) set_core(i, 1'b1, 1'b1, AW'(12'h100 + i), DW'(12'h0A0 + i));
        for (int k = 0; k < 8; k++)
            expect_gnt(k % NC, 1'b1, AW'(12'h100 + k % NC), DW'(12'h0A0 + k % NC), c + 1 + k, 1'b0);
        repeat (8) tick();
        bus.req = '0;
        repeat (4) tick();

        // Core 0 write then core 1 read of the same address
        c = cyc;
        set_core(0, 1'b1, 1'b1, 12'h040, 12'h123);
        set_core(1, 1'b1, 1'b0, 12'h040, 12'h000);
        expect_gnt(0, 1'b1, 12'h040, 12'h123, c + 1, 1'b0);
        expect_gnt(1, 1'b0, 12'h040, 12'h123, c + 2, 1'b1);
        tick();
        set_core(0, 1'b0, 1'b0, 12'h000, 12'h000);
        tick();
        set_core(1, 1'b0, 1'b0, 12'h000, 12'h000);
        repeat (5) tick();

        // Back-to-back reads from core 3, top address included
        c = cyc;
        set_core(3, 1'b1, 1'b0, 12'h001, 12'h000);
        expect_gnt(3, 1'b0, 12'h001, 12'h111, c + 1, 1'b1);
        expect_gnt(3, 1'b0, 12'h002, 12'h222, c + 2, 1'b1);
        expect_gnt(3, 1'b0, 12'h003, 12'h333, c + 3, 1'b1);
        expect_gnt(3, 1'b0, 12'hFFF, 12'h000, c + 4, 1'b1);
        tick();
        set_core(3, 1'b1, 1'b0, 12'h002, 12'h000);
        tick();
        set_core(3, 1'b1, 1'b0, 12'h003, 12'h000);
        tick();
        set_core(3, 1'b1, 1'b0, 12'hFFF, 12'h000);
        tick();
        set_core(3, 1'b0, 1'b0, 12'h000, 12'h000);
        repeat (5) tick();

        // Reset one cycle after a read grant: read is dropped, priority returns to core 0
        c = cyc;
        set_core(1, 1'b1, 1'b0, 12'h00A, 12'h000);
        expect_gnt(1, 1'b0, 12'h00A, 12'h000, c + 1, 1'b0);
        tick();
        set_core(1, 1'b0, 1'b0, 12'h000, 12'h000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_rst");
        d = cyc;
        set_core(0, 1'b1, 1'b1, 12'h200, 12'h0C0);
        set_core(3, 1'b1, 1'b1, 12'h203, 12'h0C3);
        expect_gnt(0, 1'b1, 12'h200, 12'h0C0, d + 1, 1'b0);
        expect_gnt(3, 1'b1, 12'h203, 12'h0C3, d + 2, 1'b0);
        tick();
        set_core(0, 1'b0, 1'b0, 12'h000, 12'h000);
        tick();
        set_core(3, 1'b0, 1'b0, 12'h000, 12'h000);
        repeat (6) tick();

        // Two-way contention for 5 cycles, then core 0 alone for 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef DM_ARB_STATS_EN
        chk("conflict_reset", 32'(conflict_cnt), 0);
`endif
        c = cyc;
        seq = '{0, 1, 0, 1, 0, 0, 0, 0};
        set_core(0, 1'b1, 1'b1, 12'h300, 12'h0D0);
        set_core(1, 1'b1, 1'b1, 12'h301, 12'h0D1);
        for (int k = 0; k < 8; k++)
            expect_gnt(seq[k], 1'b1, AW'(12'h300 + seq[k]), DW'(12'h0D0 + seq[k]), c + 1 + k, 1'b0);
        repeat (5) tick();
        set_core(1, 1'b0, 1'b0, 12'h000, 12'h000);
        repeat (3) tick();
        set_core(0, 1'b0, 1'b0, 12'h000, 12'h000);
`ifdef DM_ARB_STATS_EN
        chk("conflict_cnt", 32'(conflict_cnt), 5);
`endif
        repeat (4) tick();

        chk("gnt_queue_drained", gq.size(), 0);
        chk("rvalid_queue_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
